// File: rtl/knn_vote.sv
// Majority vote over a sorted k-nearest-neighbour list.
// One label compare per cycle, giving n*n scan cycles. Ties go to the label seen first.
module knn_vote #(
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 8,
  parameter int K       = 4,
  parameter int CNT_W   = $clog2(K+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [K*(DATA_W+LABEL_W)-1:0] neighbour_info,
  input  logic [CNT_W-1:0]              n_valid,
  output logic                          busy,
  output logic                          done,
  output logic [LABEL_W-1:0]            class_label,
  output logic [CNT_W-1:0]              class_votes,
  output logic [DATA_W-1:0]             class_dist
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t                        state_r, state_s;
  logic [K*(DATA_W+LABEL_W)-1:0] info_r;
  logic [CNT_W-1:0]              n_r, i_r, j_r, run_r, best_cnt_r;
  logic [LABEL_W-1:0]            best_label_r;
  logic [DATA_W-1:0]             best_dist_r;

  logic [CNT_W-1:0]              n_clamp_s, last_s, run_s;
  logic [LABEL_W-1:0]            lab_i_s, lab_j_s;
  logic [DATA_W-1:0]             dist_i_s;
  logic                          row_end_s, scan_end_s, better_s;

  assign busy = (state_r != IDLE);
  assign done = (state_r == DONE);

  // Entry selection, clamping and compare/accumulate datapath
  always_comb begin
    n_clamp_s = (n_valid > CNT_W'(K)) ? CNT_W'(K) : n_valid;
    last_s    = n_r - CNT_W'(1);
    lab_i_s   = '0;
    lab_j_s   = '0;
    dist_i_s  = '0;
    for (int k = 0; k < K; k++) begin
      if (i_r == CNT_W'(k)) begin
        lab_i_s  = info_r[k*LABEL_W +: LABEL_W];
        dist_i_s = info_r[K*LABEL_W + k*DATA_W +: DATA_W];
      end else begin
        lab_i_s  = lab_i_s;
        dist_i_s = dist_i_s;
      end
      if (j_r == CNT_W'(k)) begin
        lab_j_s = info_r[k*LABEL_W +: LABEL_W];
      end else begin
        lab_j_s = lab_j_s;
      end
    end
    run_s      = run_r + ((lab_i_s == lab_j_s) ? CNT_W'(1) : CNT_W'(0));
    row_end_s  = (j_r == last_s);
    scan_end_s = row_end_s && (i_r == last_s);
    // strict compare keeps the earlier label on a tie
    better_s   = (run_s > best_cnt_r);
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (n_clamp_s == CNT_W'(0)) ? DONE : SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      SCAN: begin
        if (scan_end_s) begin
          state_s = DONE;
        end else begin
          state_s = SCAN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture, scan counters and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      info_r       <= '0;
      n_r          <= '0;
      i_r          <= '0;
      j_r          <= '0;
      run_r        <= '0;
      best_cnt_r   <= '0;
      best_label_r <= '0;
      best_dist_r  <= '0;
      class_label  <= '0;
      class_votes  <= '0;
      class_dist   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            info_r       <= neighbour_info;
            n_r          <= n_clamp_s;
            i_r          <= '0;
            j_r          <= '0;
            run_r        <= '0;
            best_cnt_r   <= '0;
            best_label_r <= '0;
            best_dist_r  <= '0;
            if (n_clamp_s == CNT_W'(0)) begin
              class_label <= '0;
              class_votes <= '0;
              class_dist  <= '1;
            end
          end
        end
        SCAN: begin
          if (row_end_s) begin
            run_r <= '0;
            j_r   <= '0;
            i_r   <= i_r + CNT_W'(1);
            if (better_s) begin
              best_cnt_r   <= run_s;
              best_label_r <= lab_i_s;
              best_dist_r  <= dist_i_s;
            end
            if (scan_end_s) begin
              class_label <= better_s ? lab_i_s  : best_label_r;
              class_votes <= better_s ? run_s    : best_cnt_r;
              class_dist  <= better_s ? dist_i_s : best_dist_r;
            end
          end else begin
            j_r   <= j_r + CNT_W'(1);
            run_r <= run_s;
          end
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Directed-vector bench for knn_vote (K=4, 8-bit labels, 32-bit distances).
module tb_knn_vote;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [159:0] neighbour_info;
  logic [2:0]   n_valid;
  logic         busy, done;
  logic [7:0]   class_label;
  logic [2:0]   class_votes;
  logic [31:0]  class_dist;

  int tests = 0;
  int fails = 0;
  int cyc;
  int done_cnt;
  int done_cyc;

  knn_vote dut (
    .clk(clk), .rst(rst), .start(start), .neighbour_info(neighbour_info),
    .n_valid(n_valid), .busy(busy), .done(done), .class_label(class_label),
    .class_votes(class_votes), .class_dist(class_dist)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // labs = {l3,l2,l1,l0}, dists = {d3,d2,d1,d0}; cycle 1 is the one after the start edge
  task automatic run_vote(input string tag, input logic [31:0] labs, input logic [127:0] dists,
                          input logic [2:0] nv, input int exp_lat, input logic [7:0] exp_label,
                          input logic [2:0] exp_votes, input logic [31:0] exp_dist);
    @(negedge clk);
    neighbour_info = {dists, labs};
    n_valid        = nv;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_label"}, 32'(class_label), 32'(exp_label));
    check({tag, "_votes"}, 32'(class_votes), 32'(exp_votes));
    check({tag, "_dist"}, class_dist, exp_dist);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    rst            = 1'b0;
    start          = 1'b0;
    neighbour_info = '0;
    n_valid        = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_label", 32'(class_label), 32'd0);
    check("rst_votes", 32'(class_votes), 32'd0);
    check("rst_dist", class_dist, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_vote("all_same", {8'd1, 8'd1, 8'd1, 8'd1}, {32'd50, 32'd8, 32'd4, 32'd2}, 3'd4,
             17, 8'd1, 3'd4, 32'd2);
    run_vote("majority", {8'd7, 8'd5, 8'd5, 8'd3}, {32'd12, 32'd9, 32'd6, 32'd1}, 3'd4,
             17, 8'd5, 3'd2, 32'd6);
    run_vote("tie", {8'd2, 8'd9, 8'd9, 8'd2}, {32'd11, 32'd7, 32'd5, 32'd3}, 3'd4,
             17, 8'd2, 3'd2, 32'd3);
    run_vote("empty", {8'd1, 8'd1, 8'd1, 8'd1}, {32'd50, 32'd8, 32'd4, 32'd2}, 3'd0,
             1, 8'd0, 3'd0, 32'hFFFF_FFFF);
    run_vote("n2", {8'd6, 8'd6, 8'd6, 8'd4}, {32'd4, 32'd3, 32'd2, 32'd1}, 3'd2,
             5, 8'd4, 3'd1, 32'd1);
    run_vote("clamp6", {8'd7, 8'd5, 8'd5, 8'd3}, {32'd12, 32'd9, 32'd6, 32'd1}, 3'd6,
             17, 8'd5, 3'd2, 32'd6);

    // start pulses during SCAN and during the DONE cycle must be dropped
    @(negedge clk);
    neighbour_info = {{32'd11, 32'd7, 32'd5, 32'd3}, {8'd2, 8'd9, 8'd9, 8'd2}};
    n_valid        = 3'd4;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start          = 1'b0;
    neighbour_info = {{32'd40, 32'd30, 32'd20, 32'd10}, {8'd8, 8'd8, 8'd8, 8'd8}};
    n_valid        = 3'd0;
    cyc            = 1;
    done_cnt       = 0;
    done_cyc       = 0;
    while (cyc < 40) begin
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      start = (cyc == 4 || cyc == 17);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check("ignore_done_count", 32'(done_cnt), 32'd1);
    check("ignore_done_cycle", 32'(done_cyc), 32'd17);
    check("ignore_label", 32'(class_label), 32'd2);
    check("ignore_votes", 32'(class_votes), 32'd2);
    check("ignore_dist", class_dist, 32'd3);

    // reset in cycle 5 of a 4-entry vote
    @(negedge clk);
    neighbour_info = {{32'd50, 32'd8, 32'd4, 32'd2}, {8'd1, 8'd1, 8'd1, 8'd1}};
    n_valid        = 3'd4;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_label", 32'(class_label), 32'd0);
    check("midrst_votes", 32'(class_votes), 32'd0);
    check("midrst_dist", class_dist, 32'd0);
    done_cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vote("after_rst", {8'd7, 8'd5, 8'd5, 8'd3}, {32'd12, 32'd9, 32'd6, 32'd1}, 3'd4,
             17, 8'd5, 3'd2, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
